// File: rtl/hdd_cdc_fifo_drain.sv
// hdd_cdc_fifo_drain
// Read-side drain controller for the HDD CDC FIFO. Pops a programmed number
// of words from the FIFO show-ahead port into a 2-entry skid buffer and
// presents them as a valid/ready stream with last-word framing, an
// empty-FIFO starvation timeout and transfer status.
//
// Optional build macro: HDD_DRAIN_CHECKSUM_EN adds a wrap-around sum of all
// transferred words on the checksum output.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start with enable=1
// RUN   | popping FIFO words into the skid buffer
// DRAIN | no more pops; waiting for the skid buffer to empty
// DONE  | one-cycle done pulse, then back to IDLE

module hdd_cdc_fifo_drain #(
  parameter int DATA_WIDTH     = 32,
  parameter int COUNT_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMEOUT_WIDTH  = 13
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] frame_words,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_last,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic [COUNT_WIDTH-1:0] word_count
`ifdef HDD_DRAIN_CHECKSUM_EN
  ,output logic [DATA_WIDTH-1:0] checksum
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [TIMEOUT_WIDTH-1:0] STARVE_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [1:0]             state;
  logic [COUNT_WIDTH-1:0] remaining;
  logic [TIMEOUT_WIDTH-1:0] starve;

  logic [DATA_WIDTH-1:0]  buf_data [2];
  logic [1:0]             buf_last;
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [1:0]             buf_count;
  logic [1:0]             buf_count_nxt;

  logic start_ok;
  logic abort;
  logic push;
  logic xfer;
  logic starved;
  logic last_pop;

  // Pop decision uses only registered state plus the FIFO flag, so m_ready
  // never reaches fifo_rd_en combinationally.
  always_comb begin
    start_ok      = (state == S_IDLE) && start && enable;
    abort         = (state != S_IDLE) && !enable;
    fifo_rd_en    = (state == S_RUN) && !fifo_rd_empty &&
                    (remaining != '0) && (buf_count < 2'd2);
    push          = fifo_rd_en;
    last_pop      = (remaining == COUNT_WIDTH'(1));
    starved       = (state == S_RUN) && fifo_rd_empty && (remaining != '0);
    m_valid       = (buf_count != 2'd0);
    xfer          = m_valid && m_ready;
    m_data        = m_valid ? buf_data[rd_ptr] : '0;
    m_last        = m_valid && buf_last[rd_ptr];
    buf_count_nxt = buf_count + {1'b0, push} - {1'b0, xfer};
    busy          = (state != S_IDLE);
    done          = (state == S_DONE);
  end

  // Frame sequencing: remaining count, starvation timer and sticky timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      starve    <= '0;
      timeout   <= 1'b0;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            remaining <= frame_words;
            starve    <= '0;
            timeout   <= 1'b0;
            state     <= (frame_words == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (push) begin
            remaining <= remaining - COUNT_WIDTH'(1);
            starve    <= '0;
            if (last_pop) state <= S_DRAIN;
          end else if (starved) begin
            if (starve == STARVE_LAST) begin
              timeout <= 1'b1;
              state   <= S_DRAIN;
            end else begin
              starve <= starve + TIMEOUT_WIDTH'(1);
            end
          end
        end
        S_DRAIN: begin
          // Leave as soon as the final beat is accepted so done follows it
          // by a single cycle.
          if (buf_count_nxt == 2'd0) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Two-entry skid buffer; an abort discards whatever is still queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) buf_data[i] <= '0;
      buf_last  <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      buf_count <= 2'd0;
    end else if (abort) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      buf_count <= 2'd0;
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= fifo_rd_data;
        buf_last[wr_ptr] <= last_pop;
        wr_ptr           <= ~wr_ptr;
      end
      if (xfer) rd_ptr <= ~rd_ptr;
      buf_count <= buf_count_nxt;
    end
  end

  // Count of accepted beats; saturates rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_count <= '0;
    end else if (start_ok) begin
      word_count <= '0;
    end else if (xfer && (word_count != '1)) begin
      word_count <= word_count + COUNT_WIDTH'(1);
    end
  end

`ifdef HDD_DRAIN_CHECKSUM_EN
  // Modular sum of accepted beats, held after the frame ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum <= '0;
    end else if (start_ok) begin
      checksum <= '0;
    end else if (xfer) begin
      checksum <= checksum + m_data;
    end
  end
`endif

endmodule

// File: tb/tb_hdd_cdc_fifo_drain.sv
// Directed bench for hdd_cdc_fifo_drain: a show-ahead FIFO model feeds the
// DUT, a negedge monitor records accepted beats and watches stall/occupancy
// rules, and one task per scenario checks hand-derived cycle expectations.

module tb_hdd_cdc_fifo_drain;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int TO = 16;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          start;
  logic [CW-1:0] frame_words;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_empty;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] word_count;
`ifdef HDD_DRAIN_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  int checks = 0;
  int errors = 0;

  hdd_cdc_fifo_drain #(
    .DATA_WIDTH(DW), .COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .frame_words(frame_words), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .timeout(timeout), .word_count(word_count)
`ifdef HDD_DRAIN_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO model
  logic [DW-1:0] fmem [256];
  logic [7:0]    fhead = 8'd0;
  logic [7:0]    ftail = 8'd0;

  assign fifo_rd_empty = (fhead == ftail);
  assign fifo_rd_data  = fmem[fhead];

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_rd_empty) fhead <= fhead + 8'd1;
  end

  task automatic push_word(input logic [DW-1:0] w);
    fmem[ftail] = w;
    ftail = ftail + 8'd1;
  endtask

  task automatic flush_fifo();
    ftail = fhead;
  endtask

  // Beat recorder and stream-rule monitor
  logic [DW-1:0] beat_data [64];
  logic          beat_last [64];
  int            beat_n = 0;
  int            occ = 0;
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (!reset && busy) begin
      if (fifo_rd_en) begin
        checks = checks + 1;
        if (occ >= 2) begin
          errors = errors + 1;
          $display("FAIL rd_en_while_full: occupancy=%0d required<2", occ);
        end
      end
      if (prev_valid && !prev_ready) begin
        checks = checks + 1;
        if (m_valid !== 1'b1 || m_data !== prev_data) begin
          errors = errors + 1;
          $display("FAIL stall_hold: valid=%b data=%h required valid=1 data=%h",
                   m_valid, m_data, prev_data);
        end
      end
    end
    if (m_valid && m_ready && beat_n < 64) begin
      beat_data[beat_n] <= m_data;
      beat_last[beat_n] <= m_last;
      beat_n <= beat_n + 1;
    end
    occ        <= (reset || !busy) ? 0 : occ + int'(fifo_rd_en) - int'(m_valid && m_ready);
    prev_valid <= m_valid && busy && !reset;
    prev_ready <= m_ready;
    prev_data  <= m_data;
  end

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; start = 1'b0; frame_words = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks = checks + 1;
    if ({fifo_rd_en, m_valid, m_last, busy, done, timeout} !== 6'b0) begin
      errors = errors + 1;
      $display("FAIL reset_flags: got %b required 000000",
               {fifo_rd_en, m_valid, m_last, busy, done, timeout});
    end
    checks = checks + 1;
    if (m_data !== '0) begin
      errors = errors + 1;
      $display("FAIL reset_data: got %h required 0", m_data);
    end
    checks = checks + 1;
    if (word_count !== '0) begin
      errors = errors + 1;
      $display("FAIL reset_word_count: got %0d required 0", word_count);
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_frame();
    int base;
    logic exp_valid, exp_rd, exp_done, exp_last;
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    m_ready = 1'b1;
    base = beat_n;
    start = 1'b1; frame_words = CW'(8);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      exp_valid = (k >= 2 && k <= 9);
      exp_rd    = (k >= 1 && k <= 8);
      exp_done  = (k == 10);
      exp_last  = (k == 9);
      checks = checks + 1;
      if ({fifo_rd_en, m_valid, done, m_last} !== {exp_rd, exp_valid, exp_done, exp_last}) begin
        errors = errors + 1;
        $display("FAIL basic_ctrl k=%0d: rd_en/valid/done/last=%b required %b", k,
                 {fifo_rd_en, m_valid, done, m_last}, {exp_rd, exp_valid, exp_done, exp_last});
      end
      if (exp_valid) begin
        checks = checks + 1;
        if (m_data !== DW'(k - 1)) begin
          errors = errors + 1;
          $display("FAIL basic_data k=%0d: got %h required %h", k, m_data, DW'(k - 1));
        end
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    checks = checks + 1;
    if (word_count !== CW'(8) || timeout !== 1'b0 || (beat_n - base) != 8) begin
      errors = errors + 1;
      $display("FAIL basic_status: word_count=%0d timeout=%b beats=%0d required 8 0 8",
               word_count, timeout, beat_n - base);
    end
  endtask

  task automatic test_backpressure();
    int base, n;
    logic seen;
    logic [3:0] pat;
    pat = 4'b1001;
    for (int i = 0; i < 5; i++) push_word(DW'(32'h11 + i));
    base = beat_n;
    seen = 1'b0;
    start = 1'b1; frame_words = CW'(5);
    for (int k = 0; k < 80 && !seen; k++) begin
      m_ready = pat[k % 4];
      @(negedge clk);
      if (done) seen = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    m_ready = 1'b1;
    checks = checks + 1;
    if (!seen) begin
      errors = errors + 1;
      $display("FAIL bp_done: done not seen within 80 cycles, required done");
    end
    n = beat_n - base;
    checks = checks + 1;
    if (n != 5) begin
      errors = errors + 1;
      $display("FAIL bp_beats: got %0d required 5", n);
    end
    for (int i = 0; i < n && i < 5; i++) begin
      checks = checks + 1;
      if (beat_data[base + i] !== DW'(32'h11 + i) || beat_last[base + i] !== (i == 4)) begin
        errors = errors + 1;
        $display("FAIL bp_beat%0d: data=%h last=%b required %h %b", i,
                 beat_data[base + i], beat_last[base + i], DW'(32'h11 + i), (i == 4));
      end
    end
    checks = checks + 1;
    if (word_count !== CW'(5)) begin
      errors = errors + 1;
      $display("FAIL bp_word_count: got %0d required 5", word_count);
    end
  endtask

  task automatic test_starvation();
    int base, n, done_k;
    for (int i = 0; i < 3; i++) push_word(DW'(32'h21 + i));
    base = beat_n;
    done_k = -1;
    m_ready = 1'b1;
    start = 1'b1; frame_words = CW'(10);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done && done_k < 0) done_k = k;
      @(posedge clk); #1;
      start = 1'b0;
    end
    checks = checks + 1;
    if (done_k != 21) begin
      errors = errors + 1;
      $display("FAIL starve_done_cycle: got %0d required 21", done_k);
    end
    n = beat_n - base;
    checks = checks + 1;
    if (n != 3) begin
      errors = errors + 1;
      $display("FAIL starve_beats: got %0d required 3", n);
    end
    for (int i = 0; i < n && i < 3; i++) begin
      checks = checks + 1;
      if (beat_data[base + i] !== DW'(32'h21 + i) || beat_last[base + i] !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL starve_beat%0d: data=%h last=%b required %h 0", i,
                 beat_data[base + i], beat_last[base + i], DW'(32'h21 + i));
      end
    end
    checks = checks + 1;
    if (timeout !== 1'b1 || word_count !== CW'(3)) begin
      errors = errors + 1;
      $display("FAIL starve_status: timeout=%b word_count=%0d required 1 3", timeout, word_count);
    end
  endtask

  task automatic test_zero_length();
    push_word(DW'(32'h99));
    start = 1'b1; frame_words = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks = checks + 1;
      if (fifo_rd_en !== 1'b0 || done !== (k == 1)) begin
        errors = errors + 1;
        $display("FAIL zero_len k=%0d: rd_en=%b done=%b required 0 %b", k, fifo_rd_en, done, (k == 1));
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    checks = checks + 1;
    if (timeout !== 1'b0 || word_count !== '0) begin
      errors = errors + 1;
      $display("FAIL zero_len_status: timeout=%b word_count=%0d required 0 0", timeout, word_count);
    end
    flush_fifo();
  endtask

  task automatic test_ignored_start();
    int base, n;
    for (int i = 0; i < 6; i++) push_word(DW'(32'h41 + i));
    base = beat_n;
    for (int k = 0; k < 16; k++) begin
      start = (k == 0) || (k == 2);
      frame_words = (k == 0) ? CW'(4) : CW'(9);
      @(negedge clk);
      @(posedge clk); #1;
    end
    start = 1'b0;
    n = beat_n - base;
    checks = checks + 1;
    if (n != 4 || word_count !== CW'(4)) begin
      errors = errors + 1;
      $display("FAIL ign_start_beats: beats=%0d word_count=%0d required 4 4", n, word_count);
    end
    if (n == 4) begin
      checks = checks + 1;
      if (beat_last[base + 3] !== 1'b1 || beat_data[base + 3] !== DW'(32'h44)) begin
        errors = errors + 1;
        $display("FAIL ign_start_last: data=%h last=%b required 44 1",
                 beat_data[base + 3], beat_last[base + 3]);
      end
    end
    checks = checks + 1;
    if (ftail - fhead != 8'd2) begin
      errors = errors + 1;
      $display("FAIL ign_start_fifo_left: got %0d required 2", ftail - fhead);
    end
    flush_fifo();
  endtask

  task automatic test_abort();
    int base;
    logic done_seen;
    for (int i = 0; i < 8; i++) push_word(DW'(32'h51 + i));
    base = beat_n;
    done_seen = 1'b0;
    m_ready = 1'b1; enable = 1'b1;
    for (int k = 0; k < 11; k++) begin
      start = (k == 0);
      frame_words = CW'(8);
      if (k == 6) begin
        enable = 1'b0;
        m_ready = 1'b0;
      end
      @(negedge clk);
      if (done) done_seen = 1'b1;
      if (k == 7) begin
        checks = checks + 1;
        if (busy !== 1'b0 || m_valid !== 1'b0 || word_count !== CW'(4)) begin
          errors = errors + 1;
          $display("FAIL abort_state: busy=%b valid=%b word_count=%0d required 0 0 4",
                   busy, m_valid, word_count);
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks = checks + 1;
    if (done_seen !== 1'b0 || (beat_n - base) != 4) begin
      errors = errors + 1;
      $display("FAIL abort_no_done: done_seen=%b beats=%0d required 0 4", done_seen, beat_n - base);
    end
    flush_fifo();
    enable = 1'b1;
    m_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) push_word(DW'(32'h61 + i));
    m_ready = 1'b1;
    start = 1'b1; frame_words = CW'(4);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks = checks + 1;
    if (busy !== 1'b1 || m_valid !== 1'b1 || word_count !== CW'(1)) begin
      errors = errors + 1;
      $display("FAIL areset_pre: busy=%b valid=%b word_count=%0d required 1 1 1",
               busy, m_valid, word_count);
    end
    #2 reset = 1'b1;
    #1;
    checks = checks + 1;
    if ({fifo_rd_en, m_valid, m_last, busy, done, timeout} !== 6'b0 ||
        m_data !== '0 || word_count !== '0) begin
      errors = errors + 1;
      $display("FAIL areset_outputs: flags=%b data=%h word_count=%0d required 000000 0 0",
               {fifo_rd_en, m_valid, m_last, busy, done, timeout}, m_data, word_count);
    end
    @(negedge clk) reset = 1'b0;
    flush_fifo();
    @(posedge clk); #1;
  endtask

`ifdef HDD_DRAIN_CHECKSUM_EN
  task automatic test_checksum();
    logic seen;
    seen = 1'b0;
    push_word(32'hFFFF_FFFF);
    push_word(32'h0000_0002);
    m_ready = 1'b1;
    start = 1'b1; frame_words = CW'(2);
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(posedge clk); #1;
    checks = checks + 1;
    if (!seen || checksum !== DW'(32'h1)) begin
      errors = errors + 1;
      $display("FAIL checksum: done_seen=%b checksum=%h required 1 00000001", seen, checksum);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_starvation();
    test_zero_length();
    test_ignored_start();
    test_abort();
    test_async_reset();
`ifdef HDD_DRAIN_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdd_cdc_fifo_drain.md
Name: hdd_cdc_fifo_drain

Overview:
Read-side controller for the HDD-to-floppy/CPU-domain CDC FIFO. It runs entirely in the read clock domain (200/100 MHz). On a start command it pops a programmed number of flux/status words from the FIFO's show-ahead read port and presents them on a registered valid/ready stream. Framing (last flag), an empty-FIFO timeout and transfer status are provided for the DMA/capture engine.

Parameters:
DATA_WIDTH, 32, width of FIFO words and stream data
COUNT_WIDTH, 16, width of frame length and word counters
TIMEOUT_CYCLES, 4096, consecutive starved cycles in RUN before abort (must be ≥1)
TIMEOUT_WIDTH, 13, width of starvation counter (must hold TIMEOUT_CYCLES)

Ports:
clk  in  1  read-domain clock (FIFO rd_clk)
reset  in  1  asynchronous, active-high reset
enable  in  1  block enable; deassertion mid-frame aborts
start  in  1  single-cycle pulse; begin frame (ignored unless IDLE and enable=1)
frame_words  in  COUNT_WIDTH  words to transfer; sampled on accepted start
fifo_rd_en  out  1  pop strobe to FIFO
fifo_rd_data  in  DATA_WIDTH  FIFO head word (valid whenever !fifo_rd_empty)
fifo_rd_empty  in  1  FIFO empty flag
m_valid  out  1  stream data valid
m_ready  in  1  downstream ready
m_data  out  DATA_WIDTH  stream data
m_last  out  1  final word of frame
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at frame end (normal or timeout)
timeout  out  1  sticky: last frame ended by starvation; cleared on next accepted start
word_count  out  COUNT_WIDTH  words handshaked downstream in current/last frame

Behaviour:
- Reset: state IDLE. All outputs 0: fifo_rd_en, m_valid, m_data, m_last, busy, done, timeout, word_count. Skid buffer emptied.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE→RUN: start=1 and enable=1. Sets remaining=frame_words, word_count=0, timeout=0, starve=0.
- If frame_words=0, IDLE→DONE directly: no pops, done=1 the following cycle.
- RUN: fifo_rd_en = !fifo_rd_empty && remaining!=0 && buf_count<2. Depends on registered state only, with no combinational path from m_ready.
- Each pop writes {fifo_rd_data, last=(remaining==1)} into the 2-entry skid buffer at the next edge and decrements remaining.
- RUN→DRAIN when remaining reaches 0.
- Starvation: starve counter increments each RUN cycle with fifo_rd_empty=1 and remaining!=0, and clears on any pop. On reaching TIMEOUT_CYCLES: set timeout=1, RUN→DRAIN, popping stops.
- DRAIN: no pops. Stays until buf_count=0, then →DONE.
- DONE: done=1 for exactly one cycle, then →IDLE.
- Stream: m_valid=(buf_count!=0); m_data/m_last come from the head entry. Transfer occurs on m_valid&&m_ready; head advances and word_count increments (saturates at all-ones).
- Simultaneous push and transfer leave buf_count unchanged. Sustained throughput is 1 word/cycle with m_ready=1.
- m_last is asserted only on the word popped at remaining==1. A timeout-terminated frame carries no m_last.
- Latency: start at cycle 0 → first fifo_rd_en at cycle 1 (if non-empty) → m_valid at cycle 2.
- m_data must be held stable while m_valid=1 and m_ready=0.
- enable=0 in any non-IDLE state: next cycle →IDLE, skid buffer flushed, m_valid=0, no done pulse. timeout and word_count are retained.
- start while busy is ignored.

Optional Feature:
HDD_DRAIN_CHECKSUM_EN
- Defined: adds output port checksum [DATA_WIDTH-1:0]. It is a 32-bit-style modular sum (DATA_WIDTH wide, wrap-around) of every m_data transferred downstream, cleared on accepted start and reset. It holds its value after done.
- Undefined: no checksum port and no adder logic.

Test Plan:
- Basic frame: FIFO preloaded with 0x1..0x8, frame_words=8, m_ready=1 → 8 beats data 0x1..0x8 on consecutive cycles 2..9; m_last only on 0x8; done one cycle later; word_count=8; timeout=0.
- Backpressure: frame_words=5, m_ready toggled 1,0,0,1 repeating → no word lost or duplicated; m_data stable while stalled; buf_count never >2; fifo_rd_en never asserted while buffer full.
- Starvation: TIMEOUT_CYCLES=16, frame_words=10, FIFO supplies 3 words then stays empty → 3 beats, no m_last; done pulse 16 starved cycles after 3rd pop plus drain; timeout=1; word_count=3.
- Zero length and ignored start: frame_words=0 → fifo_rd_en never asserted, done 1 cycle after start. start pulsed during RUN → no effect on remaining.
- Abort and reset: enable dropped mid-frame after 4 beats → IDLE next cycle, m_valid=0, no done. Async reset asserted mid-frame between edges → all outputs 0 immediately.
- With HDD_DRAIN_CHECKSUM_EN: words 0xFFFFFFFF, 0x00000002 → checksum=0x00000001.
